// File: rtl/iob_wishbone2iob_pipe_pkg.sv
// Shared constants for the pipelined Wishbone-to-IOb bridge: FSM encodings and
// request FIFO entry geometry.
package iob_wishbone2iob_pipe_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  // Entry layout, MSB first: {address, wdata, wstrb, select}.
  function automatic int entry_width(input int addr_w, input int data_w);
    return addr_w + data_w + 2 * (data_w / 8);
  endfunction

endpackage

// File: rtl/iob_wishbone2iob_pipe_if.sv
// Bus bundles for the bridge: the Wishbone B4 pipelined side and the IOb side.
// Signal names keep the bridge's own port names so waveforms line up.
interface iob_wishbone2iob_pipe_wb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   wb_addr_i;
  logic [DATA_W/8-1:0] wb_select_i;
  logic                wb_we_i;
  logic                wb_cyc_i;
  logic                wb_stb_i;
  logic [DATA_W-1:0]   wb_data_i;
  logic                wb_stall_o;
  logic                wb_ack_o;
  logic                wb_error_o;
  logic [DATA_W-1:0]   wb_data_o;

  modport master (
    output wb_addr_i, wb_select_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_data_i,
    input  wb_stall_o, wb_ack_o, wb_error_o, wb_data_o
  );
  modport slave (
    input  wb_addr_i, wb_select_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_data_i,
    output wb_stall_o, wb_ack_o, wb_error_o, wb_data_o
  );
endinterface

interface iob_wishbone2iob_pipe_iob_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                valid_o;
  logic [ADDR_W-1:0]   address_o;
  logic [DATA_W-1:0]   wdata_o;
  logic [DATA_W/8-1:0] wstrb_o;
  logic [DATA_W-1:0]   rdata_i;
  logic                ready_i;

  modport master (
    output valid_o, address_o, wdata_o, wstrb_o,
    input  rdata_i, ready_i
  );
  modport slave (
    input  valid_o, address_o, wdata_o, wstrb_o,
    output rdata_i, ready_i
  );
endinterface

// File: rtl/iob_wb2iob_req_fifo.sv
// Request FIFO for the bridge: register array with wrap-bit pointers and a flush
// that discards every entry not yet popped.
module iob_wb2iob_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr, rd_ptr, wr_ptr_nxt;
  logic         do_push;

  assign do_push    = push & ~full;
  assign wr_ptr_nxt = do_push ? wr_ptr + 1'b1 : wr_ptr;
  assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign dout       = mem[rd_ptr[PW-1:0]];

  // NOTE: state registers use non-blocking assignments so every always_ff reads
  // the pre-edge value of its neighbours regardless of evaluation order.
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      if (flush)                rd_ptr <= wr_ptr_nxt;
      else if (pop && !empty)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone define
  // which entries are meaningful, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/iob_wishbone2iob_pipe.sv
// Pipelined Wishbone B4 slave to IOb master bridge: queues requests, issues them
// one at a time on IOb, returns in-order ack/error with a per-transfer timeout.
module iob_wishbone2iob_pipe
  import iob_wishbone2iob_pipe_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input logic                        clk_i,
  input logic                        arst_i,
  iob_wishbone2iob_pipe_wb_if.slave  wb,
  iob_wishbone2iob_pipe_iob_if.master iob
);
  localparam int SEL_W   = DATA_W / 8;
  localparam int ENTRY_W = entry_width(ADDR_W, DATA_W);
  localparam int CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic               push, pop, flush, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] push_entry, head_entry;
  logic [0:0]         state;
  logic [CNT_W-1:0]   timeout_cnt;
  logic               timeout_hit;
  logic               drop;
  logic [SEL_W-1:0]   cur_sel;
  logic [DATA_W-1:0]  sel_mask;

  // The pointers are registers, so a full FIFO stalls even if it pops this cycle.
  assign wb.wb_stall_o = fifo_full;
  assign push          = wb.wb_cyc_i & wb.wb_stb_i & ~fifo_full;
  assign flush         = ~wb.wb_cyc_i;
  assign pop           = (state == ST_IDLE) & ~fifo_empty & wb.wb_cyc_i;
  assign push_entry    = {wb.wb_addr_i, wb.wb_data_i,
                          (wb.wb_we_i ? wb.wb_select_i : {SEL_W{1'b0}}), wb.wb_select_i};
  assign timeout_hit   = (TIMEOUT != 0) && (timeout_cnt == CNT_W'(TIMEOUT - 1));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < SEL_W; i++) sel_mask[8*i +: 8] = {8{cur_sel[i]}};
  end

  iob_wb2iob_req_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .din    (push_entry),
    .dout   (head_entry),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state          <= ST_IDLE;
      iob.valid_o    <= 1'b0;
      iob.address_o  <= '0;
      iob.wdata_o    <= '0;
      iob.wstrb_o    <= '0;
      cur_sel        <= '0;
      timeout_cnt    <= '0;
      drop           <= 1'b0;
      wb.wb_ack_o    <= 1'b0;
      wb.wb_error_o  <= 1'b0;
      wb.wb_data_o   <= '0;
    end else begin
      wb.wb_ack_o   <= 1'b0;
      wb.wb_error_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            {iob.address_o, iob.wdata_o, iob.wstrb_o, cur_sel} <= head_entry;
            iob.valid_o <= 1'b1;
            timeout_cnt <= '0;
            state       <= ST_REQ;
          end
        end
        default: begin
          // A completion landing on the timeout cycle still counts as success.
          if (iob.ready_i) begin
            iob.valid_o  <= 1'b0;
            state        <= ST_IDLE;
            drop         <= 1'b0;
            wb.wb_ack_o  <= ~drop & wb.wb_cyc_i;
            wb.wb_data_o <= (iob.wstrb_o == '0) ? (iob.rdata_i & sel_mask) : '0;
          end else if (timeout_hit) begin
            iob.valid_o   <= 1'b0;
            state         <= ST_IDLE;
            drop          <= 1'b0;
            wb.wb_error_o <= ~drop & wb.wb_cyc_i;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
            // IOb cannot be cancelled: let it finish, but swallow its response.
            if (!wb.wb_cyc_i) drop <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_wishbone2iob_pipe.sv
// Scoreboard bench for the Wishbone-to-IOb bridge: stimulus queues expected IOb
// requests and Wishbone responses; independent monitors pop and compare.
module tb_iob_wishbone2iob_pipe;
  localparam int TIMEOUT = 8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  sel;
    int          delay;   // ready_i in valid cycle delay+1; >= TIMEOUT never answers
    logic [31:0] rdata;
  } req_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  iob_wishbone2iob_pipe_wb_if  #(.ADDR_W(32), .DATA_W(32)) wb ();
  iob_wishbone2iob_pipe_iob_if #(.ADDR_W(32), .DATA_W(32)) iob ();

  iob_wishbone2iob_pipe #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .wb     (wb),
    .iob    (iob)
  );

  req_t iob_q[$];
  rsp_t resp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   busy   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a request either completes inside the timeout window or errors.
  function automatic rsp_t model(input req_t r);
    rsp_t e;
    e.err  = (r.delay >= TIMEOUT);
    e.data = '0;
    if (!e.err && !r.we)
      for (int i = 0; i < 4; i++) if (r.sel[i]) e.data[8*i +: 8] = r.rdata[8*i +: 8];
    return e;
  endfunction

  function automatic req_t mk(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                              input logic [3:0] sel, input int delay, input logic [31:0] rdata);
    req_t r;
    r.addr = addr; r.wdata = wdata; r.we = we; r.sel = sel; r.delay = delay; r.rdata = rdata;
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the request was accepted.
  task automatic issue(input req_t r);
    int guard = 0;
    wb.wb_cyc_i    = 1'b1;
    wb.wb_stb_i    = 1'b1;
    wb.wb_addr_i   = r.addr;
    wb.wb_data_i   = r.wdata;
    wb.wb_we_i     = r.we;
    wb.wb_select_i = r.sel;
    while (wb.wb_stall_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("accept_in_budget", guard < 200, 1);
    iob_q.push_back(r);
    resp_q.push_back(model(r));
    @(negedge clk);
    wb.wb_stb_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((resp_q.size() != 0 || iob_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_budget", n < budget, 1);
    repeat (2) @(negedge clk);
  endtask

  // IOb responder and request monitor.
  initial begin : responder
    req_t cur;
    int   k = 0;
    bit   acked = 1'b0, rst_hit = 1'b0;
    iob.ready_i = 1'b0;
    iob.rdata_i = '0;
    forever begin
      @(negedge clk);
      iob.ready_i = 1'b0;
      iob.rdata_i = $urandom;
      if (arst) rst_hit = 1'b1;
      if (!busy && iob.valid_o) begin
        check("iob_req_expected", iob_q.size() != 0, 1);
        if (iob_q.size() != 0) begin
          cur = iob_q.pop_front();
          check("iob_address", iob.address_o, cur.addr);
          check("iob_wdata", iob.wdata_o, cur.wdata);
          check("iob_wstrb", iob.wstrb_o, cur.we ? cur.sel : 4'b0000);
        end else begin
          cur = mk(0, 0, 0, 0, 0, 0);
        end
        busy = 1'b1; k = 0; acked = 1'b0; rst_hit = arst;
      end
      if (busy) begin
        if (iob.valid_o) begin
          k++;
          if (k == cur.delay + 1) begin
            check("iob_address_held", iob.address_o, cur.addr);
            iob.ready_i = 1'b1;
            iob.rdata_i = cur.rdata;
            acked = 1'b1;
          end
        end else begin
          busy = 1'b0;
          if (!rst_hit) check("valid_len", k, (cur.delay < TIMEOUT) ? cur.delay + 1 : TIMEOUT);
          if (!acked) iob.ready_i = 1'b1;  // late completion, bridge is idle and must ignore it
        end
      end
    end
  end

  // Wishbone response monitor.
  initial begin : wb_monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (wb.wb_ack_o || wb.wb_error_o) begin
        check("rsp_expected", resp_q.size() != 0, 1);
        if (resp_q.size() != 0) begin
          e = resp_q.pop_front();
          check("rsp_kind_ack_err", {wb.wb_ack_o, wb.wb_error_o}, {~e.err, e.err});
          if (!e.err) check("rsp_data", wb.wb_data_o, e.data);
        end
      end
    end
  end

  initial begin : stimulus
    arst = 1'b1;
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_addr_i = '0; wb.wb_data_i = '0; wb.wb_select_i = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", iob.valid_o, 0);
    check("rst_stall", wb.wb_stall_o, 0);
    check("rst_ack", wb.wb_ack_o, 0);
    check("rst_error", wb.wb_error_o, 0);
    check("rst_address", iob.address_o, 0);
    check("rst_wstrb", iob.wstrb_o, 0);
    check("rst_rdata", wb.wb_data_o, 0);
    arst = 1'b0;
    @(negedge clk);

    // Single masked read.
    issue(mk(32'h10, 32'h0, 1'b0, 4'b0011, 3, 32'hDEADBEEF));
    wait_done(100);

    // Back-to-back writes fill the FIFO behind the in-flight request.
    for (int i = 0; i < 6; i++) begin
      issue(mk(32'h100 + 32'(4*i), $urandom, 1'b1, 4'hF, 5, $urandom));
      if (i == 4) check("stall_when_full", wb.wb_stall_o, 1);
    end
    wait_done(300);

    // Timeout, boundary completion on the last cycle, and a second timeout.
    issue(mk(32'h300, 32'h0, 1'b0, 4'hF, 20, $urandom));
    wait_done(100);
    issue(mk(32'h304, 32'h0, 1'b0, 4'b1100, TIMEOUT - 1, 32'h12345678));
    issue(mk(32'h308, 32'h0, 1'b0, 4'hF, TIMEOUT, $urandom));
    wait_done(100);

    // Short cyc abort: the in-flight read finishes silently, queued ones vanish.
    issue(mk(32'h400, 32'h0, 1'b0, 4'hF, 6, $urandom));
    issue(mk(32'h404, 32'h0, 1'b0, 4'hF, 1, $urandom));
    issue(mk(32'h408, 32'h0, 1'b0, 4'hF, 1, $urandom));
    wb.wb_cyc_i = 1'b0;
    void'(iob_q.pop_back()); void'(iob_q.pop_back());
    resp_q.delete();
    @(negedge clk);
    wb.wb_cyc_i = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_stall", wb.wb_stall_o, 0);
    check("abort_no_issue", iob_q.size(), 0);
    check("abort_idle", busy, 0);
    issue(mk(32'h40C, 32'h0, 1'b0, 4'b0101, 2, $urandom));
    wait_done(100);

    // Reset while a request is in flight with two more queued.
    issue(mk(32'h500, 32'h0, 1'b0, 4'hF, 6, $urandom));
    issue(mk(32'h504, 32'h0, 1'b0, 4'hF, 1, $urandom));
    issue(mk(32'h508, 32'h0, 1'b0, 4'hF, 1, $urandom));
    arst = 1'b1;
    iob_q.delete();
    resp_q.delete();
    @(negedge clk);
    check("rst_mid_valid", iob.valid_o, 0);
    check("rst_mid_stall", wb.wb_stall_o, 0);
    check("rst_mid_ack_err", {wb.wb_ack_o, wb.wb_error_o}, 0);
    check("rst_mid_wdata", iob.wdata_o, 0);
    @(negedge clk);
    arst = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_mid_no_issue", busy, 0);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      issue(mk($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               int'($urandom_range(0, 9)), $urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_done(2000);
    check("final_iob_queue_empty", iob_q.size(), 0);
    check("final_rsp_queue_empty", resp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
